// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_pkg
//  Description : Shared constants for the Frogger road lanes. Holds the lane
//                row range, the frog start row, the per-lane initial obstacle
//                patterns, the per-lane base periods (in frames) and the
//                lane-controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package frogger_pkg;

  localparam int LANE_ROW_FIRST = 8;
  localparam int LANE_ROW_LAST  = 13;
  localparam int START_ROW      = 14;
  localparam int TABLE_LANES    = 6;

  // Bit i set = obstacle at column i (table written for a 16-tile pattern).
  localparam logic [15:0] LANE_INIT_PATTERN [TABLE_LANES] = '{
    16'h0707, 16'h0C30, 16'h3003, 16'h0F0F, 16'h6060, 16'h0381
  };

  localparam int LANE_BASE_PERIOD [TABLE_LANES] = '{8, 6, 10, 4, 7, 5};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_HIT      = 2'd2,
    ST_COOLDOWN = 2'd3
  } lane_state_t;

  // Lanes beyond the table reuse it cyclically.
  function automatic logic [15:0] lane_init_pattern(input int lane);
    return LANE_INIT_PATTERN[lane % TABLE_LANES];
  endfunction

  function automatic int lane_base_period(input int lane);
    return LANE_BASE_PERIOD[lane % TABLE_LANES];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_shifter
//  Description : One road lane: a rotating obstacle pattern plus a frame
//                counter. The lane rotates one tile when the counter reaches
//                its latched period; the period is only re-latched when the
//                counter clears so a speed change never cuts a count short.
//  Ports       : i_Clk, i_Rst    - clock, synchronous active-high reset
//                i_Restart       - reload initial pattern, clear counter
//                i_Advance       - one frame elapsed while the lane may move
//                i_Period        - requested period in frames (>= 2)
//                o_Pattern       - current obstacle pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_shifter #(
  parameter int                     C_PATTERN_W = 16,
  parameter int                     C_PERIOD_W  = 6,
  parameter bit                     C_MOVE_UP   = 1'b1,
  parameter logic [C_PATTERN_W-1:0] C_INIT      = '0
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Restart,
  input  logic                   i_Advance,
  input  logic [C_PERIOD_W-1:0]  i_Period,
  output logic [C_PATTERN_W-1:0] o_Pattern
);

  logic [C_PATTERN_W-1:0] r_pattern;
  logic [C_PERIOD_W-1:0]  r_count;
  logic [C_PERIOD_W-1:0]  r_period;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Restart) begin
      r_pattern <= C_INIT;
      r_count   <= '0;
      r_period  <= i_Period;
    end else if (i_Advance) begin
      if (r_count == r_period - C_PERIOD_W'(1)) begin
        if (C_MOVE_UP)
          r_pattern <= {r_pattern[C_PATTERN_W-2:0], r_pattern[C_PATTERN_W-1]};
        else
          r_pattern <= {r_pattern[0], r_pattern[C_PATTERN_W-1:1]};
        r_count  <= '0;
        r_period <= i_Period;
      end else begin
        r_count <= r_count + C_PERIOD_W'(1);
      end
    end
  end

  assign o_Pattern = r_pattern;

endmodule
`default_nettype wire

// File: rtl/lane_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lane_ctrl
//  Description : Road-lane controller. Moves C_NUM_LANES obstacle lanes on
//                frame ticks, detects frog collisions (one pulse per life)
//                and flags obstacle tiles for the renderer.
//  Ports       : i_Clk, i_Rst                  - clock, sync active-high reset
//                i_Frame_Tick                  - one pulse per video frame
//                i_Game_Active                 - game running
//                i_Score                       - score (speed-up level)
//                i_Frogger_X/Y                 - frog tile position
//                i_Col_Count_Div/Row_Count_Div - tile being drawn
//                o_Collided                    - one-cycle collision pulse
//                o_Draw_Obstacle               - obstacle on drawn tile (reg)
//  Config      : LANE_SPEEDUP_EN - shorten lane periods as the score rises
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_ctrl
  import frogger_pkg::*;
#(
  parameter int C_NUM_LANES = 6,
  parameter int C_PATTERN_W = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_Game_Active,
  input  logic [6:0] i_Score,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic       o_Collided,
  output logic       o_Draw_Obstacle
);

  localparam int C_PERIOD_W = 6;

  lane_state_t            r_state;
  logic [C_PATTERN_W-1:0] w_patterns [C_NUM_LANES];
  logic                   w_frog_bit;
  logic                   w_tile_bit;
  logic                   w_restart;
  logic                   w_advance;
  logic                   w_hit;

`ifdef LANE_SPEEDUP_EN
  logic [4:0] w_level;
  logic       unused_score_lsb;
  assign w_level          = i_Score[6:2];
  assign unused_score_lsb = ^i_Score[1:0];
`else
  logic       unused_score;
  assign unused_score = ^i_Score;
`endif

  // Lanes reload on entry to RUN and move only while the game runs.
  assign w_restart = (r_state == ST_IDLE) && i_Game_Active;
  assign w_advance = (r_state == ST_RUN) && i_Game_Active && i_Frame_Tick;

  for (genvar l = 0; l < C_NUM_LANES; l++) begin : g_lane
    localparam logic [C_PERIOD_W-1:0] C_BASE = C_PERIOD_W'(lane_base_period(l));
    logic [C_PERIOD_W-1:0] w_period;

`ifdef LANE_SPEEDUP_EN
    // Faster lanes with score, never below two frames per tile.
    always_comb begin
      if (C_BASE > {1'b0, w_level} + 6'd2)
        w_period = C_BASE - {1'b0, w_level};
      else
        w_period = 6'd2;
    end
`else
    assign w_period = C_BASE;
`endif

    lane_shifter #(
      .C_PATTERN_W (C_PATTERN_W),
      .C_PERIOD_W  (C_PERIOD_W),
      .C_MOVE_UP   (((LANE_ROW_FIRST + l) % 2) == 0),
      .C_INIT      (C_PATTERN_W'(lane_init_pattern(l)))
    ) u_shifter (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Restart (w_restart),
      .i_Advance (w_advance),
      .i_Period  (w_period),
      .o_Pattern (w_patterns[l])
    );
  end

  // Row/column lookup by exhaustive compare: any row outside the lanes or
  // column beyond the pattern simply never matches and reads as empty.
  always_comb begin
    w_frog_bit = 1'b0;
    w_tile_bit = 1'b0;
    for (int l = 0; l < C_NUM_LANES; l++) begin
      for (int c = 0; c < C_PATTERN_W; c++) begin
        if ((LANE_ROW_FIRST + l) <= LANE_ROW_LAST) begin
          if (i_Frogger_Y == 6'(LANE_ROW_FIRST + l) && i_Frogger_X == 6'(c))
            w_frog_bit = w_patterns[l][c];
          if (i_Row_Count_Div == 6'(LANE_ROW_FIRST + l) && i_Col_Count_Div == 6'(c))
            w_tile_bit = w_patterns[l][c];
        end
      end
    end
  end

  // Patterns are read before any same-cycle rotation takes effect.
  assign w_hit = (r_state == ST_RUN) && w_frog_bit;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state         <= ST_IDLE;
      o_Collided      <= 1'b0;
      o_Draw_Obstacle <= 1'b0;
    end else begin
      o_Draw_Obstacle <= w_tile_bit;
      o_Collided      <= 1'b0;
      if (!i_Game_Active) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_RUN;
          ST_RUN: begin
            if (w_hit) begin
              r_state    <= ST_HIT;
              o_Collided <= 1'b1;
            end
          end
          ST_HIT:  r_state <= ST_COOLDOWN;
          ST_COOLDOWN: begin
            if (i_Frogger_Y == 6'(START_ROW))
              r_state <= ST_RUN;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/lane_ctrl.md
LANE_CTRL -- requirements
Module: lane_ctrl

Interface
REQ-001 SHALL have parameter C_NUM_LANES, default 6, number of road lanes, occupying rows 8..13.
REQ-002 SHALL have parameter C_PATTERN_W, default 16, lane pattern width in tiles; the pattern wraps.
REQ-003 SHALL have port i_Clk, input, 1, the single system clock.
REQ-004 SHALL have port i_Rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_Frame_Tick, input, 1, one-cycle pulse once per video frame.
REQ-006 SHALL have port i_Game_Active, input, 1; lanes move and collisions are detected only while it is high.
REQ-007 SHALL have port i_Score, input, 7, current score, used for speed-up.
REQ-008 SHALL have ports i_Frogger_X and i_Frogger_Y, input, 6 each, the frog tile position.
REQ-009 SHALL have ports i_Col_Count_Div and i_Row_Count_Div, input, 6 each, the tile currently being drawn.
REQ-010 SHALL have port o_Collided, output, 1, one-cycle collision pulse to the frog controller.
REQ-011 SHALL have port o_Draw_Obstacle, output, 1, registered flag meaning an obstacle occupies the drawn tile.

Function
REQ-012 SHALL hold one C_PATTERN_W-bit rotating pattern per lane; bit i marks an obstacle at column i.
REQ-013 SHALL keep a frame counter per lane; on i_Frame_Tick in RUN, when the counter equals period-1, the lane rotates by one tile and the counter clears; otherwise the counter increments.
REQ-014 SHALL move even rows (8, 10, 12) toward higher X (new[i] = old[i-1], new[0] = old[W-1]) and odd rows toward lower X.
REQ-015 SHALL use base periods, in frames, of lanes 0..5 = 8, 6, 10, 4, 7, 5.
REQ-016 SHALL implement a state machine with states IDLE, RUN, HIT and COOLDOWN.
- IDLE→RUN when i_Game_Active = 1.
- RUN→HIT on collision.
- HIT→COOLDOWN unconditionally after one cycle.
- COOLDOWN→RUN when i_Frogger_Y = 14.
- Any state→IDLE when i_Game_Active = 0.
REQ-017 SHALL declare a collision when the state is RUN, i_Frogger_Y is in 8..13, and the pattern bit of that lane at i_Frogger_X is 1.
REQ-018 SHALL assert o_Collided for exactly the HIT cycle, one clock after detection, giving at most one pulse per life.
REQ-019 SHALL use the pre-rotation pattern for detection when a rotation and a detection fall in the same cycle.
REQ-020 SHALL treat i_Frogger_X ≥ C_PATTERN_W, or a row outside 8..13, as no collision.
REQ-021 SHALL set o_Draw_Obstacle one cycle after the tile inputs, to 1 only when the row is in 8..13, the column is < C_PATTERN_W and the pattern bit is 1; this holds in every state.
REQ-022 SHALL keep patterns and counters frozen in IDLE, HIT and COOLDOWN, with patterns still drawn.
REQ-023 SHALL restore the initial patterns and clear the counters on the IDLE→RUN transition.

Reset
REQ-024 SHALL apply the following on i_Rst = 1 at a clock edge:
- state = IDLE;
- all counters = 0;
- patterns = package initial values;
- o_Collided = 0;
- o_Draw_Obstacle = 0.
REQ-025 SHALL let reset mid-HIT suppress any further o_Collided pulse; reset SHALL take priority over every other input.

Configuration
REQ-026 SHALL, when LANE_SPEEDUP_EN is defined, compute the period as level = i_Score[6:2], then period = base - level if base > level + 2, else 2.
REQ-027 SHALL, without LANE_SPEEDUP_EN, use the fixed base period and ignore i_Score.
REQ-028 SHALL latch a period change only when that lane's counter clears, never mid-count.

Structure
REQ-029 SHALL place in the shared package frogger_pkg:
- lane row constants (first 8, last 13);
- start row 14;
- the initial pattern table;
- the base period table;
- the state encoding typedef.
REQ-030 SHALL implement one sub-module, lane_shifter (pattern register, frame counter, direction parameter), instantiated C_NUM_LANES times.

Verification
REQ-031 SHALL cover reset: assert i_Rst mid-RUN → state IDLE, o_Collided = 0 and patterns equal to initial values on the next cycle.
REQ-032 SHALL cover rotation: active game, lane 3 base 4, 4 frame ticks → row 11 pattern rotated one tile toward lower X; 3 ticks → unchanged.
REQ-033 SHALL cover collision: frog at (5, 9) on a set bit → exactly one o_Collided pulse one cycle later; frog held there 100 cycles → no second pulse until Y = 14 is seen.
REQ-034 SHALL cover speed-up: with LANE_SPEEDUP_EN, score 16 (level 4), lane 0 → period 4; lane 3 → clamped to 2; without the macro → periods 8 and 4.
REQ-035 SHALL cover draw and boundaries: col 16, row 9 → o_Draw_Obstacle = 0; row 7 or row 14 → 0 and no collision.
REQ-036 SHALL cover deactivation: i_Game_Active falls in COOLDOWN → IDLE and lanes frozen; rises again → initial patterns restored.
